inst_seq: RTL and testbench
===========================

# inst_seq

Instruction sequencer for the 10-instruction processor. Owns the program counter, fetches 32-bit instruction words from a synchronous program memory, resolves NOP/BRA/HLT locally, and issues all other instructions to the `cpu` core through a one-cycle issue / done handshake. It sits between program memory and `cpu`, replacing the per-cycle opcode-to-IReg packing with a self-running fetch/execute loop.

## Interface

**Parameters**
- `BUSW`, 32: instruction/data word width.
- `PSRW`, 5: status register width.
- `PCW`, 6: program counter width; memory depth is 2^PCW.
- `TMO`, 255: maximum EXEC cycles before watchdog abort (≥1).
- `CNTW`, 16: retired-instruction counter width.

**Ports**
- `clk` in 1: clock. One clock domain; all logic is sampled on `posedge clk`.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle pulse. Starts execution at PC 0 from IDLE or HALT. Ignored in any other state.
- `imem_addr` out PCW: program memory address.
- `imem_data` in BUSW: program memory read data, valid 1 cycle after `imem_addr`.
- `ireg` out BUSW: the decoded instruction presented to `cpu` (`IReg`).
- `issue` out 1: one-cycle strobe. `ireg` is valid and the core must start executing it.
- `core_done` in 1: the core has completed the issued instruction.
- `psr` in PSRW: core status (`PsrOut`).
- `pc` out PCW: address of the current instruction.
- `busy` out 1: high in any state other than IDLE and HALT.
- `halted` out 1: high in HALT.
- `err` out 1: sticky. Set by an illegal opcode or a watchdog abort. Cleared by `start` or `rst`.
- `retired` out CNTW: count of completed instructions. Saturates at the maximum value and does not wrap.

## Operation

- **Opcodes** (`ireg[31:28]`): NOP=0, LD=1, STR=2, BRA=3, XOR=4, ADD=5, ROT=6, SHF=7, HLT=8, CMP=9. Values 10–15 are illegal.
- **State transitions:**
  - IDLE —start→ FETCH.
  - FETCH: drive `imem_addr`=`pc`. Next state is DECODE.
  - DECODE: latch `imem_data` into `ireg`, then dispatch:
    - NOP: `pc`+1, `retired`+1, go to FETCH.
    - BRA: `pc` = taken ? `ireg[PCW-1:0]` : `pc`+1. Increment `retired`. Go to FETCH.
    - HLT: increment `retired`, go to HALT. `pc` is unchanged.
    - Illegal opcode: set `err`, go to HALT.
    - Any other opcode: go to ISSUE.
  - ISSUE: `issue`=1 for exactly this cycle. Next state is EXEC.
  - EXEC: wait for `core_done`. On `core_done`: `pc`+1, `retired`+1, go to FETCH. If the wait counter reaches `TMO` with no `core_done`: set `err`, go to HALT.
  - HALT —start→ FETCH, with `pc`=0 and `err`=0. `retired` is not cleared.
- **Branch conditions** use `ireg[26:24]` and the `psr` value sampled in DECODE:
  - 0 always
  - 1 parity (`psr[1]`)
  - 2 even (`psr[2]`)
  - 3 carry (`psr[0]`)
  - 4 negative (`psr[3]`)
  - 5 zero (`psr[4]`)
  - 6 no-carry
  - 7 non-negative
- **PC arithmetic:** PC is modulo 2^PCW; 2^PCW−1 plus 1 gives 0. The BRA target is truncated to PCW bits.
- **`core_done` handling:** `core_done` is ignored outside EXEC, including in the ISSUE cycle itself.
- **Reset:** `rst` is honoured in every state, including mid-EXEC. It forces IDLE and all registers to reset values. Any in-flight core operation is abandoned.

## Timing

- **Reset values:**
  - `imem_addr`=0, `ireg`=0 (NOP encoding), `pc`=0, `retired`=0
  - `issue`=0, `busy`=0, `halted`=0, `err`=0
- **`start` latency:** a `start` pulse in cycle N puts the FSM in FETCH in N+1 and `busy` goes to 1 in N+1.
- **Local instructions** (NOP, BRA, HLT) take 2 cycles: FETCH, DECODE.
- **Core instructions:** FETCH, DECODE, ISSUE, then EXEC for k≥1 cycles. Minimum 4 cycles, with `core_done` in the first EXEC cycle.
- **Watchdog:** the EXEC counter starts at 1 on EXEC entry. The abort takes effect in the cycle after the counter equals `TMO`.
- **Output stability:** `ireg` holds its value from DECODE until the next DECODE.
- **Registered outputs:** all outputs are registered. There are no combinational paths from input to output.

## Structure

- **Package `proc_pkg`:** opcode constants, `REGTYPE`/`IMMTYPE`, branch condition codes, PSR bit indices, and the FSM state enum.
- **Sub-module `cond_eval`:** combinational. Inputs are `cc[2:0]` and `psr`; output is `taken`. It is instantiated once.
- **Remaining logic:** a single FSM with the PC, watchdog counter and retired counter.

## Test plan

- **Straight line:** memory = {ADD, XOR, HLT}, `core_done` 2 cycles after each `issue` → exactly 2 `issue` pulses, `retired`=3, `halted`=1, `pc`=2, `err`=0.
- **Branch:**
  - Case A: memory[0] = BRA cc=5 target=7, `psr[4]`=1 → `imem_addr` is 7 on the next FETCH.
  - Case B: the same instruction with `psr[4]`=0 → `imem_addr` is 1 on the next FETCH.
- **PC wrap:** BRA cc=0 to 63, memory[63]=NOP, memory[0]=HLT → fetch sequence 0, 63, 0; `halted`=1.
- **Watchdog:** `TMO`=4, memory[0]=LD, `core_done` never asserted → `err`=1 and `halted`=1 exactly 5 cycles after `issue`. A following `start` clears `err` and refetches address 0.
- **Illegal opcode / reset mid-EXEC:**
  - Opcode 0xC → `err`=1, `halted`=1, no `issue` pulse.
  - Separately, `rst` asserted during EXEC → all outputs equal reset values the next cycle. A late `core_done` then causes no `retired` increment.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, branch condition
// codes, status-register bit positions and the sequencer FSM states.
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_STR = 4'd2;
    localparam logic [3:0] OP_BRA = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_ROT = 4'd6;
    localparam logic [3:0] OP_SHF = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    // Operand-type flag carried in ireg[27]; only the core interprets it.
    localparam logic REGTYPE = 1'b0;
    localparam logic IMMTYPE = 1'b1;

    localparam logic [2:0] CC_ALWAYS = 3'd0;
    localparam logic [2:0] CC_PARITY = 3'd1;
    localparam logic [2:0] CC_EVEN   = 3'd2;
    localparam logic [2:0] CC_CARRY  = 3'd3;
    localparam logic [2:0] CC_NEG    = 3'd4;
    localparam logic [2:0] CC_ZERO   = 3'd5;
    localparam logic [2:0] CC_NCARRY = 3'd6;
    localparam logic [2:0] CC_NNEG   = 3'd7;

    localparam int PSR_CARRY  = 0;
    localparam int PSR_PARITY = 1;
    localparam int PSR_EVEN   = 2;
    localparam int PSR_NEG    = 3;
    localparam int PSR_ZERO   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/inst_seq_if.sv
// Bus between the sequencer, program memory and the execution core.
// The sequencer is the master; memory and core together form the slave.
interface inst_seq_if #(
    parameter int BUSW = 32,
    parameter int PSRW = 5,
    parameter int PCW  = 6
);

    logic [PCW-1:0]  imem_addr;
    logic [BUSW-1:0] imem_data;
    logic [BUSW-1:0] ireg;
    logic            issue;
    logic            core_done;
    logic [PSRW-1:0] psr;

    modport master (
        output imem_addr,
        output ireg,
        output issue,
        input  imem_data,
        input  core_done,
        input  psr
    );

    modport slave (
        input  imem_addr,
        input  ireg,
        input  issue,
        output imem_data,
        output core_done,
        output psr
    );

endinterface

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition code and the core status
// word to a taken/not-taken decision.
module cond_eval
    import proc_pkg::*;
#(
    parameter int PSRW = 5
) (
    input  logic [2:0]      cc,
    input  logic [PSRW-1:0] psr,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_ALWAYS: taken = 1'b1;
            CC_PARITY: taken = psr[PSR_PARITY];
            CC_EVEN:   taken = psr[PSR_EVEN];
            CC_CARRY:  taken = psr[PSR_CARRY];
            CC_NEG:    taken = psr[PSR_NEG];
            CC_ZERO:   taken = psr[PSR_ZERO];
            CC_NCARRY: taken = ~psr[PSR_CARRY];
            CC_NNEG:   taken = ~psr[PSR_NEG];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer: owns the PC, fetches from synchronous program memory,
// resolves NOP/BRA/HLT locally and hands every other opcode to the core.
module inst_seq
    import proc_pkg::*;
#(
    parameter int BUSW = 32,
    parameter int PSRW = 5,
    parameter int PCW  = 6,
    parameter int TMO  = 255,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    inst_seq_if.master      bus,
    output logic [PCW-1:0]  pc,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [CNTW-1:0] retired
);

    localparam int WDW = $clog2(TMO + 1);

    state_t          state;
    logic [WDW-1:0]  wd_cnt;
    logic [3:0]      op;
    logic            taken;
    logic [PCW-1:0]  pc_inc;
    logic [PCW-1:0]  br_next;
    logic [CNTW-1:0] retired_inc;

    assign op          = bus.imem_data[BUSW-1 -: 4];
    assign pc_inc      = pc + PCW'(1);
    assign br_next     = taken ? bus.imem_data[PCW-1:0] : pc_inc;
    assign retired_inc = (retired == '1) ? retired : retired + CNTW'(1);

    cond_eval #(
        .PSRW (PSRW)
    ) u_cond (
        .cc    (bus.imem_data[26:24]),
        .psr   (bus.psr),
        .taken (taken)
    );

    // imem_addr is reloaded together with pc so the read of the next word is
    // already in flight during FETCH and its data lands in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pc            <= '0;
            bus.imem_addr <= '0;
            bus.ireg      <= '0;
            bus.issue     <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            err           <= 1'b0;
            retired       <= '0;
            wd_cnt        <= '0;
        end else begin
            bus.issue <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state         <= S_FETCH;
                        pc            <= '0;
                        bus.imem_addr <= '0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        halted        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    bus.ireg <= bus.imem_data;
                    if (!is_legal(op)) begin
                        err    <= 1'b1;
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        case (op)
                            OP_NOP: begin
                                pc            <= pc_inc;
                                bus.imem_addr <= pc_inc;
                                retired       <= retired_inc;
                                state         <= S_FETCH;
                            end
                            OP_BRA: begin
                                pc            <= br_next;
                                bus.imem_addr <= br_next;
                                retired       <= retired_inc;
                                state         <= S_FETCH;
                            end
                            OP_HLT: begin
                                retired <= retired_inc;
                                state   <= S_HALT;
                                busy    <= 1'b0;
                                halted  <= 1'b1;
                            end
                            default: begin
                                state     <= S_ISSUE;
                                bus.issue <= 1'b1;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    state  <= S_EXEC;
                    wd_cnt <= WDW'(1);
                end
                S_EXEC: begin
                    // A completion in the final allowed cycle still counts.
                    if (bus.core_done) begin
                        pc            <= pc_inc;
                        bus.imem_addr <= pc_inc;
                        retired       <= retired_inc;
                        state         <= S_FETCH;
                    end else if (wd_cnt == WDW'(TMO)) begin
                        err    <= 1'b1;
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: directed and random programs are run through a
// program-level model; issue, retire and halt events are scoreboarded.
module tb_inst_seq;

    localparam int BUSW = 32;
    localparam int PSRW = 5;
    localparam int PCW  = 6;
    localparam int TMO  = 4;
    localparam int CNTW = 16;
    localparam int MEMD = 64;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [BUSW-1:0] word;
    } issue_t;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [CNTW-1:0] count;
    } retire_t;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic            err;
        logic [CNTW-1:0] count;
        logic            abort;
    } halt_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PCW-1:0]  pc;
    logic            busy;
    logic            halted;
    logic            err;
    logic [CNTW-1:0] retired;

    inst_seq_if #(.BUSW(BUSW), .PSRW(PSRW), .PCW(PCW)) bus ();

    inst_seq #(
        .BUSW (BUSW),
        .PSRW (PSRW),
        .PCW  (PCW),
        .TMO  (TMO),
        .CNTW (CNTW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus.master),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .err     (err),
        .retired (retired)
    );

    logic [BUSW-1:0] mem [MEMD];
    issue_t          issue_q  [$];
    retire_t         retire_q [$];
    halt_t           halt_q   [$];

    int              n_checks = 0;
    int              n_fail = 0;
    int              core_delay = 1;
    logic [PSRW-1:0] psr_val = '0;
    int              exp_ret = 0;
    int              exp_issues = 0;
    int              issues_seen = 0;
    int              issue_base = 0;
    int              cyc = 0;

    always #5 clk = ~clk;

    // Synchronous program memory: data follows the address by one cycle.
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit cond_holds(input logic [2:0] cc, input logic [PSRW-1:0] s);
        case (cc)
            3'd0:    return 1'b1;
            3'd1:    return s[1];
            3'd2:    return s[2];
            3'd3:    return s[0];
            3'd4:    return s[3];
            3'd5:    return s[4];
            3'd6:    return !s[0];
            default: return !s[3];
        endcase
    endfunction

    function automatic issue_t mk_issue(input int p, input logic [BUSW-1:0] w);
        issue_t e;
        e.pc   = PCW'(p);
        e.word = w;
        return e;
    endfunction

    function automatic retire_t mk_retire(input int p);
        retire_t e;
        e.pc    = PCW'(p);
        e.count = CNTW'(exp_ret);
        return e;
    endfunction

    function automatic halt_t mk_halt(input int p, input bit e_err, input bit e_abort);
        halt_t e;
        e.pc    = PCW'(p);
        e.err   = e_err;
        e.count = CNTW'(exp_ret);
        e.abort = e_abort;
        return e;
    endfunction

    function automatic logic [3:0] core_op(input int k);
        case (k)
            0:       return 4'd1;
            1:       return 4'd2;
            2:       return 4'd4;
            3:       return 4'd5;
            4:       return 4'd6;
            5:       return 4'd7;
            default: return 4'd9;
        endcase
    endfunction

    // Interprets the program in mem instruction by instruction, queueing the
    // core issues, retirements and final halt state the sequencer must show.
    task automatic build_expect();
        int              p;
        int              op;
        int              steps;
        bit              done;
        logic [BUSW-1:0] w;
        p = 0;
        steps = 0;
        done = 1'b0;
        exp_issues = 0;
        while (!done && steps < 256) begin
            w = mem[p];
            op = int'(w[31:28]);
            steps++;
            if (op > 9) begin
                halt_q.push_back(mk_halt(p, 1'b1, 1'b0));
                done = 1'b1;
            end else if (op == 0 || op == 3) begin
                if (op == 3 && cond_holds(w[26:24], psr_val)) p = int'(w[PCW-1:0]);
                else p = (p + 1) % MEMD;
                exp_ret++;
                retire_q.push_back(mk_retire(p));
            end else if (op == 8) begin
                exp_ret++;
                retire_q.push_back(mk_retire(p));
                halt_q.push_back(mk_halt(p, 1'b0, 1'b0));
                done = 1'b1;
            end else begin
                issue_q.push_back(mk_issue(p, w));
                exp_issues++;
                if (core_delay == 0 || core_delay > TMO) begin
                    halt_q.push_back(mk_halt(p, 1'b1, 1'b1));
                    done = 1'b1;
                end else begin
                    p = (p + 1) % MEMD;
                    exp_ret++;
                    retire_q.push_back(mk_retire(p));
                end
            end
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < MEMD; i++) mem[i] = 32'h8000_0000;
    endtask

    function automatic logic [BUSW-1:0] bra_word(input logic [2:0] cc, input logic [PCW-1:0] tgt);
        return {4'h3, 1'b0, cc, 18'h0, tgt};
    endfunction

    task automatic gen_random_program();
        int              len;
        int              r;
        logic [3:0]      op;
        logic [BUSW-1:0] w;
        fill_halt();
        len = int'($urandom_range(3, 12));
        for (int i = 0; i < len - 1; i++) begin
            r = int'($urandom_range(0, 19));
            w = $urandom;
            if (r < 4) op = 4'h0;
            else if (r < 9) op = 4'h3;
            else if (r == 19) op = 4'($urandom_range(10, 15));
            else op = core_op(int'($urandom_range(0, 6)));
            w[31:28] = op;
            if (op == 4'h3) w[PCW-1:0] = PCW'($urandom_range(i + 1, len - 1));
            mem[i] = w;
        end
        mem[len-1] = {4'h8, 28'($urandom)};
        psr_val = PSRW'($urandom);
        r = int'($urandom_range(0, 9));
        core_delay = (r == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_imem_addr"}, bus.imem_addr, 0);
        check_output({tag, "_ireg"}, bus.ireg, 0);
        check_output({tag, "_pc"}, pc, 0);
        check_output({tag, "_retired"}, retired, 0);
        check_output({tag, "_issue"}, bus.issue, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_halted"}, halted, 0);
        check_output({tag, "_err"}, err, 0);
    endtask

    task automatic apply_stimulus();
        bus.psr = psr_val;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_output("start_busy", busy, 1);
        check_output("start_halted", halted, 0);
        check_output("start_err_clear", err, 0);
        check_output("start_fetch_addr", bus.imem_addr, 0);
    endtask

    task automatic finish_run();
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 1000) begin
            tick(1);
            n++;
        end
        if (halted !== 1'b1) report_fail("halt_wait", "timed out waiting for halted");
        tick(3);
        check_output("issue_q_drained", issue_q.size(), 0);
        check_output("retire_q_drained", retire_q.size(), 0);
        check_output("halt_q_drained", halt_q.size(), 0);
        check_output("issue_count", issues_seen - issue_base, exp_issues);
        issue_q.delete();
        retire_q.delete();
        halt_q.delete();
    endtask

    task automatic run_program();
        build_expect();
        issue_base = issues_seen;
        apply_stimulus();
        finish_run();
    endtask

    // Core stand-in: answers each issue with core_done after core_delay cycles
    // (0 means never), regardless of what the sequencer does meanwhile.
    initial begin : core_model
        bus.core_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.issue && core_delay != 0) begin
                repeat (core_delay) begin
                    @(posedge clk);
                    #1;
                end
                bus.core_done = 1'b1;
                @(posedge clk);
                #1;
                bus.core_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [CNTW-1:0] prev_ret;
        logic            prev_halt;
        logic            prev_issue;
        logic            rst_d;
        int              last_issue_cyc;
        issue_t          ie;
        retire_t         re;
        halt_t           he;
        prev_ret = '0;
        prev_halt = 1'b0;
        prev_issue = 1'b0;
        rst_d = 1'b1;
        last_issue_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || rst_d) begin
                prev_ret = retired;
                prev_halt = halted;
                prev_issue = bus.issue;
                rst_d = rst;
                continue;
            end
            if (bus.issue) begin
                issues_seen++;
                last_issue_cyc = cyc;
                check_output("issue_single_cycle", prev_issue, 0);
                if (issue_q.size() == 0) begin
                    report_fail("issue_unexpected", "issue with no expected instruction");
                end else begin
                    ie = issue_q.pop_front();
                    check_output("issue_pc", pc, ie.pc);
                    check_output("issue_ireg", bus.ireg, ie.word);
                end
            end
            if (retired != prev_ret) begin
                if (retire_q.size() == 0) begin
                    report_fail("retire_unexpected", "retired changed with no expected retirement");
                end else begin
                    re = retire_q.pop_front();
                    check_output("retire_count", retired, re.count);
                    check_output("retire_pc", pc, re.pc);
                    check_output("retire_fetch_addr", bus.imem_addr, re.pc);
                end
            end
            if (halted && !prev_halt) begin
                if (halt_q.size() == 0) begin
                    report_fail("halt_unexpected", "halted rose with no expected halt");
                end else begin
                    he = halt_q.pop_front();
                    check_output("halt_pc", pc, he.pc);
                    check_output("halt_err", err, he.err);
                    check_output("halt_retired", retired, he.count);
                    check_output("halt_busy", busy, 0);
                    if (he.abort) check_output("watchdog_latency", cyc - last_issue_cyc, TMO + 1);
                end
            end
            prev_ret = retired;
            prev_halt = halted;
            prev_issue = bus.issue;
        end
    end

    initial begin : guard
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.psr = '0;
        fill_halt();
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset("reset");

        $display("[TB] straight line");
        fill_halt();
        mem[0] = {4'h5, 28'h0123456};
        mem[1] = {4'h4, 28'h0abcdef};
        mem[2] = 32'h8000_0000;
        core_delay = 2;
        psr_val = '0;
        run_program();

        $display("[TB] branch taken / not taken");
        fill_halt();
        mem[0] = bra_word(3'd5, 6'd7);
        psr_val = 5'b10000;
        run_program();
        psr_val = 5'b01111;
        run_program();

        $display("[TB] pc wrap");
        fill_halt();
        mem[0] = bra_word(3'd0, 6'd63);
        mem[63] = 32'h0000_0000;
        psr_val = PSRW'($urandom);
        issue_base = issues_seen;
        exp_issues = 0;
        exp_ret++;
        retire_q.push_back(mk_retire(63));
        exp_ret++;
        retire_q.push_back(mk_retire(0));
        exp_ret++;
        retire_q.push_back(mk_retire(0));
        halt_q.push_back(mk_halt(0, 1'b0, 1'b0));
        apply_stimulus();
        n = 0;
        while (pc !== 6'd63 && n < 50) begin
            tick(1);
            n++;
        end
        if (pc !== 6'd63) report_fail("wrap_branch", "timed out waiting for pc 63");
        mem[0] = 32'h8000_0000;
        finish_run();

        $display("[TB] watchdog and restart");
        fill_halt();
        mem[0] = {4'h1, 28'h0000042};
        core_delay = 0;
        run_program();
        mem[0] = 32'h8000_0000;
        core_delay = 1;
        run_program();

        $display("[TB] watchdog boundary");
        fill_halt();
        mem[0] = {4'h9, 28'h1111111};
        core_delay = TMO;
        run_program();
        core_delay = TMO + 1;
        run_program();

        $display("[TB] illegal opcode");
        fill_halt();
        mem[0] = {4'hC, 28'h0};
        core_delay = 1;
        run_program();

        $display("[TB] random programs");
        for (int k = 0; k < 25; k++) begin
            gen_random_program();
            run_program();
        end

        $display("[TB] reset during EXEC");
        fill_halt();
        mem[0] = {4'h1, 28'h0000077};
        core_delay = 3;
        issue_base = issues_seen;
        issue_q.push_back(mk_issue(0, mem[0]));
        apply_stimulus();
        n = 0;
        while (bus.issue !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (bus.issue !== 1'b1) report_fail("midexec_issue", "timed out waiting for issue");
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset("midexec");
        exp_ret = 0;
        tick(4);
        check_output("late_done_retired", retired, 0);
        check_output("late_done_busy", busy, 0);
        check_output("midexec_issue_count", issues_seen - issue_base, 1);
        check_output("midexec_issue_q", issue_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
